tiny_rv_regfile_mp: RTL and testbench

Parametrised multi-port integer register file for the tiny_rv core. It is the successor to the fixed 2R1W file, generalised in data width, entry count and read-port count, with two write ports and write enables. Entry 0 is hardwired to zero. A hardware clear sequencer zeroes the array after reset. It sits between decode (read ports) and writeback (write ports).

---
 rtl/tiny_rv_regfile_mp.sv | 108 ++++++++++
 tb/tb_tiny_rv_regfile_mp.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/tiny_rv_regfile_mp.sv
// Parametrised multi-port register file for tiny_rv: NREAD combinational read ports, two write ports, post-reset clear sequencer.
// Optional same-cycle write-to-read forwarding is enabled by defining TINY_RV_RF_BYPASS_EN.
module tiny_rv_regfile_mp #(
    parameter  int XLEN  = 32,
    parameter  int NREGS = 32,
    parameter  int NREAD = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [NREAD*AW-1:0]   i_rd_addr,
    output logic [NREAD*XLEN-1:0] o_rd_data,
    input  logic                  i_wr0_en,
    input  logic [AW-1:0]         i_wr0_addr,
    input  logic [XLEN-1:0]       i_wr0_data,
    input  logic                  i_wr1_en,
    input  logic [AW-1:0]         i_wr1_addr,
    input  logic [XLEN-1:0]       i_wr1_data,
    output logic                  o_busy,
    output logic                  o_wr_collide
);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   ptr_q, ptr_d;
    logic            collide_q, collide_d;
    logic [XLEN-1:0] mem_q [NREGS-1:1];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= CLEAR;
            ptr_q     <= AW'(1);
            collide_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            collide_q <= collide_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        collide_d = 1'b0;
        case (state_q)
            CLEAR: begin
                ptr_d = ptr_q + AW'(1);
                if (ptr_q == AW'(NREGS - 1)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                collide_d = i_wr0_en && i_wr1_en && (i_wr0_addr == i_wr1_addr)
                            && (i_wr0_addr != '0);
            end
            default: state_d = CLEAR;
        endcase
    end

    // Entry 0 has no storage; port 1 is checked first so it wins a same-address collision.
    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            for (int e = 1; e < NREGS; e++) begin
                if (state_q == CLEAR) begin
                    if (ptr_q == AW'(e)) begin
                        mem_q[e] <= '0;
                    end
                end else if (i_wr1_en && (i_wr1_addr == AW'(e))) begin
                    mem_q[e] <= i_wr1_data;
                end else if (i_wr0_en && (i_wr0_addr == AW'(e))) begin
                    mem_q[e] <= i_wr0_data;
                end
            end
        end
    end

    always_comb begin
        o_rd_data = '0;
        for (int k = 0; k < NREAD; k++) begin
            for (int e = 1; e < NREGS; e++) begin
                if (i_rd_addr[k*AW +: AW] == AW'(e)) begin
                    o_rd_data[k*XLEN +: XLEN] = mem_q[e];
                end
            end
`ifdef TINY_RV_RF_BYPASS_EN
            if ((state_q == RUN) && (i_rd_addr[k*AW +: AW] != '0)) begin
                if (i_wr0_en && (i_wr0_addr == i_rd_addr[k*AW +: AW])) begin
                    o_rd_data[k*XLEN +: XLEN] = i_wr0_data;
                end
                if (i_wr1_en && (i_wr1_addr == i_rd_addr[k*AW +: AW])) begin
                    o_rd_data[k*XLEN +: XLEN] = i_wr1_data;
                end
            end
`endif
            if (state_q == CLEAR) begin
                o_rd_data[k*XLEN +: XLEN] = '0;
            end
        end
    end

    assign o_busy       = (state_q == CLEAR);
    assign o_wr_collide = collide_q;

endmodule

// File: tb/tb_tiny_rv_regfile_mp.sv
// Directed testbench for tiny_rv_regfile_mp with default parameters (XLEN=32, NREGS=32, NREAD=2).
// Expected read data is queued when a read is set up and popped when the outputs are sampled.
module tb_tiny_rv_regfile_mp;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int NREAD = 2;
   localparam int AW    = 5;

   logic                  clk;
   logic                  rstN;
   logic [NREAD*AW-1:0]   rdAddr;
   logic [NREAD*XLEN-1:0] rdData;
   logic                  wr0En, wr1En;
   logic [AW-1:0]         wr0Addr, wr1Addr;
   logic [XLEN-1:0]       wr0Data, wr1Data;
   logic                  busy, wrCollide;

   typedef struct {
      string           tag;
      int              port;
      logic [XLEN-1:0] expected;
   } readExp_t;

   readExp_t scoreQ[$];
   int       nAssert = 0;
   int       nFail   = 0;
   int       clearEdges;

   tiny_rv_regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD)) dut (
      .i_clk        (clk),
      .i_rst_n      (rstN),
      .i_rd_addr    (rdAddr),
      .o_rd_data    (rdData),
      .i_wr0_en     (wr0En),
      .i_wr0_addr   (wr0Addr),
      .i_wr0_data   (wr0Data),
      .i_wr1_en     (wr1En),
      .i_wr1_addr   (wr1Addr),
      .i_wr1_data   (wr1Data),
      .o_busy       (busy),
      .o_wr_collide (wrCollide)
   );

   // Free-running 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive both write ports for the next rising edge
   task automatic applyStimulus(input logic e0, input logic [AW-1:0] a0, input logic [XLEN-1:0] d0,
                                input logic e1, input logic [AW-1:0] a1, input logic [XLEN-1:0] d1);
      wr0En = e0; wr0Addr = a0; wr0Data = d0;
      wr1En = e1; wr1Addr = a1; wr1Data = d1;
   endtask

   // Advance one rising edge and settle just after it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Set a read address and queue the value that port must return
   task automatic pushRead(input string tag, input int port, input logic [AW-1:0] addr,
                           input logic [XLEN-1:0] expected);
      readExp_t item;
      rdAddr[port*AW +: AW] = addr;
      item.tag = tag;
      item.port = port;
      item.expected = expected;
      scoreQ.push_back(item);
   endtask

   // Compare a single observed value against its required value
   task automatic checkValue(input string tag, input logic [XLEN-1:0] observed,
                             input logic [XLEN-1:0] expected);
      nAssert++;
      assert (observed === expected) else begin
         nFail++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Sample on the falling edge and drain every queued read expectation
   task automatic checkOutput();
      readExp_t item;
      @(negedge clk);
      while (scoreQ.size() > 0) begin
         item = scoreQ.pop_front();
         checkValue(item.tag, rdData[item.port*XLEN +: XLEN], item.expected);
      end
   endtask

   // Count busy edges after reset release, optionally attempting a write on one edge
   task automatic runClear(input int wrAtEdge, output int edges);
      edges = 0;
      while (busy && edges < 200) begin
         if (edges + 1 == wrAtEdge) applyStimulus(1'b1, 5'd3, 32'h1, 1'b0, '0, '0);
         else                       applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
         tick();
         edges++;
      end
      applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
   endtask

   // Read every entry through both ports and expect zero
   task automatic checkAllZero(input string tag);
      for (int a = 0; a < NREGS; a += 2) begin
         pushRead(tag, 0, AW'(a), '0);
         pushRead(tag, 1, AW'(a + 1), '0);
         checkOutput();
      end
   endtask

   // Linear directed sequence
   initial begin
      rstN = 1'b0;
      rdAddr = '0;
      applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);

      // Reset and initial clear
      repeat (3) tick();
      checkValue("rst_busy", 32'(busy), 32'd1);
      checkValue("rst_collide", 32'(wrCollide), 32'd0);
      rstN = 1'b1;
      runClear(0, clearEdges);
      checkValue("clear_edges", 32'(clearEdges), 32'd31);
      checkAllZero("clear_zero");

      // Basic dual write to distinct addresses
      applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd9, 32'h12345678);
      tick();
      applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
      pushRead("rd_x5", 0, 5'd5, 32'hDEADBEEF);
      pushRead("rd_x9", 1, 5'd9, 32'h12345678);
      checkOutput();
      checkValue("distinct_no_collide", 32'(wrCollide), 32'd0);

      // Write to x0 is discarded and never flags a collision
      applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 32'hFFFFFFFF);
      tick();
      applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
      pushRead("rd_x0_p0", 0, 5'd0, '0);
      pushRead("rd_x0_p1", 1, 5'd0, '0);
      checkOutput();
      checkValue("x0_no_collide", 32'(wrCollide), 32'd0);

      // Same-address collision: port 1 wins, one-cycle pulse
      applyStimulus(1'b1, 5'd7, 32'hAAAA0000, 1'b1, 5'd7, 32'h5555FFFF);
      tick();
      applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
      checkValue("collide_pulse", 32'(wrCollide), 32'd1);
      pushRead("rd_x7", 0, 5'd7, 32'h5555FFFF);
      pushRead("rd_x5_kept", 1, 5'd5, 32'hDEADBEEF);
      checkOutput();
      tick();
      checkValue("collide_drop", 32'(wrCollide), 32'd0);

      // Same-cycle read of a write target
      applyStimulus(1'b1, 5'd4, 32'h0BADF00D, 1'b0, '0, '0);
`ifdef TINY_RV_RF_BYPASS_EN
      pushRead("rd_x4_same", 0, 5'd4, 32'h0BADF00D);
`else
      pushRead("rd_x4_same", 0, 5'd4, 32'h0);
`endif
      pushRead("rd_x9_same", 1, 5'd9, 32'h12345678);
      checkOutput();
      tick();
      applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
      pushRead("rd_x4_after", 0, 5'd4, 32'h0BADF00D);
      checkOutput();

      // Write during clear is discarded and reset re-clears stored data
      applyStimulus(1'b1, 5'd20, 32'hCAFEF00D, 1'b1, 5'd31, 32'h31313131);
      tick();
      applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
      pushRead("rd_x20_pre", 0, 5'd20, 32'hCAFEF00D);
      pushRead("rd_x31_pre", 1, 5'd31, 32'h31313131);
      checkOutput();
      rstN = 1'b0;
      tick();
      rstN = 1'b1;
      pushRead("busy_read", 0, 5'd20, '0);
      checkOutput();
      runClear(10, clearEdges);
      checkValue("clear2_edges", 32'(clearEdges), 32'd31);
      pushRead("rd_x3_discard", 0, 5'd3, '0);
      pushRead("rd_x5_cleared", 1, 5'd5, '0);
      checkOutput();

      // Reset asserted mid-clear restarts the full sequence
      applyStimulus(1'b1, 5'd20, 32'h0000BEEF, 1'b0, '0, '0);
      tick();
      applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
      rstN = 1'b0;
      tick();
      rstN = 1'b1;
      repeat (12) tick();
      rstN = 1'b0;
      tick();
      checkValue("midrst_busy", 32'(busy), 32'd1);
      rstN = 1'b1;
      runClear(0, clearEdges);
      checkValue("clear3_edges", 32'(clearEdges), 32'd31);
      checkAllZero("clear3_zero");

      $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
      $finish;
   end

endmodule
